// File: rtl/i2c_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_arb_pkg
// Description : Shared types and constants for the I2C core arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STROBE    = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4,
    VERIFY    = 3'd5,
    RESPOND   = 3'd6,
    DRAIN     = 3'd7
  } state_e;

  localparam int C_TIMEOUT_DEFAULT = 100000;

  // MPU-6050 register map entries used by the attached clients
  localparam logic [7:0] C_MPU_SLAVE_ADDR = 8'hD0;
  localparam logic [7:0] C_MPU_REG_WAKE   = 8'h6B;
  localparam logic [7:0] C_MPU_REG_ACCEL  = 8'h3D;

endpackage
`default_nettype wire

// File: rtl/i2c_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : i2c_rr_pick
// Description : Combinational round-robin picker, searching from last+1.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_rr_pick
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(i_last_grant) + k) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_grant_idx      = w_cand;
        o_grant[w_cand]  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_arbiter
// Description : Round-robin sharing of one I2C core among NUM_REQ masters.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = C_TIMEOUT_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ-1:0]     req_rnw_i,
  input  logic [8*NUM_REQ-1:0]   req_slave_addr_i,
  input  logic [8*NUM_REQ-1:0]   req_command_byte_i,
  input  logic [8*NUM_REQ-1:0]   req_din_i,
  input  logic [8*NUM_REQ-1:0]   req_num_bytes_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [7:0]             rsp_data_o,
  output logic                   rsp_error_o,
  input  logic                   i2c_busy_i,
  input  logic                   i2c_rxak_i,
  input  logic                   i2c_arb_lost_i,
  input  logic                   i2c_write_done_i,
  input  logic                   i2c_data_out_valid_i,
  input  logic [7:0]             i2c_data_out_i,
  output logic                   i2c_write_o,
  output logic                   i2c_read_o,
  output logic [7:0]             i2c_slave_addr_o,
  output logic [7:0]             i2c_din_o,
  output logic [7:0]             i2c_command_byte_o,
  output logic [7:0]             i2c_num_bytes_o,
  output logic                   timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  state_e             r_state;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_owner;
  logic               r_rnw;
  logic [7:0]         r_slave_addr;
  logic [7:0]         r_command_byte;
  logic [7:0]         r_din;
  logic [7:0]         r_num_bytes;
  logic               r_write;
  logic               r_read;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [7:0]         r_rsp_data;
  logic               r_rsp_error;
  logic [7:0]         r_rd_data;
  logic               r_timeout;
  logic [WD_W-1:0]    r_wd_cnt;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic               w_wd_hit;
  logic               w_done;

  i2c_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req        (req_valid_i),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;
  assign w_wd_hit   = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_done     = r_rnw ? i2c_data_out_valid_i : i2c_write_done_i;

  // Pulses default low each cycle; a grant decision registers req_ready for
  // the following (accept) cycle, in which the requester fields are captured.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state        <= IDLE;
      r_last_grant   <= IDX_W'(NUM_REQ - 1);
      r_owner        <= '0;
      r_rnw          <= 1'b0;
      r_slave_addr   <= '0;
      r_command_byte <= '0;
      r_din          <= '0;
      r_num_bytes    <= '0;
      r_write        <= 1'b0;
      r_read         <= 1'b0;
      r_req_ready    <= '0;
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
      r_rsp_error    <= 1'b0;
      r_rd_data      <= '0;
      r_timeout      <= 1'b0;
      r_wd_cnt       <= '0;
    end else begin
      r_req_ready <= '0;
      r_write     <= 1'b0;
      r_read      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_wd_cnt    <= '0;
      case (r_state)
        IDLE: begin
          if (|r_req_ready) begin
            r_rnw          <= req_rnw_i[r_owner];
            r_slave_addr   <= req_slave_addr_i[8*r_owner +: 8];
            r_command_byte <= req_command_byte_i[8*r_owner +: 8];
            r_din          <= req_din_i[8*r_owner +: 8];
            r_num_bytes    <= req_num_bytes_i[8*r_owner +: 8];
            r_rd_data      <= '0;
            r_state        <= LOAD;
          end else if (|req_valid_i && !i2c_busy_i) begin
            r_req_ready  <= w_grant;
            r_owner      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
          end
        end
        LOAD: begin
          r_write <= !r_rnw;
          r_read  <= r_rnw;
          r_state <= STROBE;
        end
        STROBE: r_state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (i2c_busy_i) begin
            r_state <= WAIT_DONE;
          end else if (w_wd_hit) begin
            r_rsp_valid <= w_owner_oh;
            r_rsp_data  <= r_rd_data;
            r_rsp_error <= 1'b1;
            r_timeout   <= 1'b1;
            r_state     <= RESPOND;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (w_done) begin
            if (r_rnw) r_rd_data <= i2c_data_out_i;
            r_state <= VERIFY;
          end else if (w_wd_hit) begin
            r_rsp_valid <= w_owner_oh;
            r_rsp_data  <= r_rd_data;
            r_rsp_error <= 1'b1;
            r_timeout   <= 1'b1;
            r_state     <= RESPOND;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        VERIFY: begin
          // Reads expect rxak high because the master NACKs the last byte
          r_rsp_valid <= w_owner_oh;
          r_rsp_data  <= r_rd_data;
          r_rsp_error <= i2c_arb_lost_i | (r_rnw ? !i2c_rxak_i : i2c_rxak_i);
          r_state     <= RESPOND;
        end
        RESPOND: r_state <= DRAIN;
        DRAIN: begin
          if (!i2c_busy_i) begin
            r_state <= IDLE;
            if (|req_valid_i) begin
              r_req_ready  <= w_grant;
              r_owner      <= w_grant_idx;
              r_last_grant <= w_grant_idx;
            end
          end else if (w_wd_hit) begin
            r_timeout <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o        = r_req_ready;
  assign rsp_valid_o        = r_rsp_valid;
  assign rsp_data_o         = r_rsp_data;
  assign rsp_error_o        = r_rsp_error;
  assign i2c_write_o        = r_write;
  assign i2c_read_o         = r_read;
  assign i2c_slave_addr_o   = r_slave_addr;
  assign i2c_din_o          = r_din;
  assign i2c_command_byte_o = r_command_byte;
  assign i2c_num_bytes_o    = r_num_bytes;
  assign timeout_o          = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_arbiter
// Description : Directed self-checking bench for i2c_arbiter (2 requesters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_arbiter;
  import i2c_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [1:0]  req_valid_i, req_rnw_i;
  logic [15:0] req_slave_addr_i, req_command_byte_i, req_din_i, req_num_bytes_i;
  logic [1:0]  req_ready_o, rsp_valid_o;
  logic [7:0]  rsp_data_o;
  logic        rsp_error_o;
  logic        i2c_busy_i, i2c_rxak_i, i2c_arb_lost_i, i2c_write_done_i, i2c_data_out_valid_i;
  logic [7:0]  i2c_data_out_i;
  logic        i2c_write_o, i2c_read_o;
  logic [7:0]  i2c_slave_addr_o, i2c_din_o, i2c_command_byte_o, i2c_num_bytes_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(16)) u_dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_valid_i(req_valid_i), .req_rnw_i(req_rnw_i),
    .req_slave_addr_i(req_slave_addr_i), .req_command_byte_i(req_command_byte_i),
    .req_din_i(req_din_i), .req_num_bytes_i(req_num_bytes_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o),
    .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
    .i2c_busy_i(i2c_busy_i), .i2c_rxak_i(i2c_rxak_i), .i2c_arb_lost_i(i2c_arb_lost_i),
    .i2c_write_done_i(i2c_write_done_i), .i2c_data_out_valid_i(i2c_data_out_valid_i),
    .i2c_data_out_i(i2c_data_out_i), .i2c_write_o(i2c_write_o), .i2c_read_o(i2c_read_o),
    .i2c_slave_addr_o(i2c_slave_addr_o), .i2c_din_o(i2c_din_o),
    .i2c_command_byte_o(i2c_command_byte_o), .i2c_num_bytes_o(i2c_num_bytes_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int k, input logic rnw, input logic [7:0] addr,
                         input logic [7:0] cmd, input logic [7:0] din, input logic [7:0] nb);
    req_rnw_i[k]               = rnw;
    req_slave_addr_i[8*k +: 8]   = addr;
    req_command_byte_i[8*k +: 8] = cmd;
    req_din_i[8*k +: 8]          = din;
    req_num_bytes_i[8*k +: 8]    = nb;
  endtask

  task automatic wait_ready(output logic [1:0] rdy, output int n);
    rdy = 2'b00;
    n   = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      n++;
      if (req_ready_o != 2'b00) begin
        rdy = req_ready_o;
        break;
      end
    end
    if (rdy == 2'b00) check("ready_wait_expired", 64'd0, 64'd1);
  endtask

  // One transaction with a well-behaved core; T is the accept cycle.
  task automatic serve(input logic drop, input logic rnw, input logic [31:0] exp_fields,
                       input logic [7:0] rdata, input logic rxak, input logic arb,
                       output logic [1:0] g_ready, output int g_wait, output logic [1:0] g_rsp,
                       output logic [7:0] g_data, output logic g_err);
    wait_ready(g_ready, g_wait);
    if (drop) req_valid_i = req_valid_i & ~req_ready_o;
    tick();
    check("strobe_t1", {i2c_write_o, i2c_read_o}, 2'b00);
    check("fields_t1", {i2c_slave_addr_o, i2c_command_byte_o, i2c_din_o, i2c_num_bytes_o}, exp_fields);
    tick();
    check("strobe_t2", {i2c_write_o, i2c_read_o}, rnw ? 2'b01 : 2'b10);
    tick();
    check("strobe_t3", {i2c_write_o, i2c_read_o}, 2'b00);
    i2c_busy_i = 1'b1;
    tick();
    if (rnw) i2c_data_out_valid_i = 1'b1;
    else     i2c_write_done_i     = 1'b1;
    i2c_data_out_i = rdata;
    i2c_rxak_i     = rxak;
    i2c_arb_lost_i = arb;
    tick();
    i2c_data_out_valid_i = 1'b0;
    i2c_write_done_i     = 1'b0;
    check("rsp_early", rsp_valid_o, 2'b00);
    tick();
    g_rsp  = rsp_valid_o;
    g_data = rsp_data_o;
    g_err  = rsp_error_o;
    i2c_busy_i     = 1'b0;
    i2c_rxak_i     = 1'b0;
    i2c_arb_lost_i = 1'b0;
    tick();
    check("rsp_single_pulse", rsp_valid_o, 2'b00);
  endtask

  logic [1:0] rdy, rsp;
  logic [7:0] dat;
  logic       err;
  int         nw;
  logic [1:0] seen;

  initial begin
    reset_n_i = 1'b0;
    req_valid_i = '0; req_rnw_i = '0;
    req_slave_addr_i = '0; req_command_byte_i = '0; req_din_i = '0; req_num_bytes_i = '0;
    i2c_busy_i = 0; i2c_rxak_i = 0; i2c_arb_lost_i = 0;
    i2c_write_done_i = 0; i2c_data_out_valid_i = 0; i2c_data_out_i = '0;
    repeat (3) tick();
    check("reset_outputs", {req_ready_o, rsp_valid_o, rsp_data_o, rsp_error_o, i2c_write_o,
          i2c_read_o, i2c_slave_addr_o, i2c_din_o, i2c_command_byte_o, i2c_num_bytes_o, timeout_o}, 64'd0);
    reset_n_i = 1'b1;

    // Single write from requester 0
    set_req(0, 1'b0, C_MPU_SLAVE_ADDR, C_MPU_REG_WAKE, 8'h00, 8'd2);
    req_valid_i = 2'b01;
    serve(1'b1, 1'b0, 32'hD06B0002, 8'h00, 1'b0, 1'b0, rdy, nw, rsp, dat, err);
    check("w_ready", rdy, 2'b01);
    check("w_rsp", rsp, 2'b01);
    check("w_err", err, 1'b0);
    check("w_data", dat, 8'h00);

    // Single read from requester 1
    set_req(1, 1'b1, C_MPU_SLAVE_ADDR, C_MPU_REG_ACCEL, 8'h00, 8'd2);
    req_valid_i = 2'b10;
    serve(1'b1, 1'b1, 32'hD03D0002, 8'hFC, 1'b1, 1'b0, rdy, nw, rsp, dat, err);
    check("r_ready", rdy, 2'b10);
    check("r_rsp", rsp, 2'b10);
    check("r_data", dat, 8'hFC);
    check("r_err", err, 1'b0);

    // Both held: grants alternate 0,1,0,1 at 8-cycle spacing
    set_req(0, 1'b0, 8'hD0, 8'h6B, 8'hA0, 8'd2);
    set_req(1, 1'b0, 8'hD0, 8'h6B, 8'hA1, 8'd2);
    req_valid_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, 1'b0, {16'hD06B, 8'hA0 + 8'(i % 2), 8'd2}, 8'h00, 1'b0, 1'b0,
            rdy, nw, rsp, dat, err);
      check("rr_ready", rdy, (i % 2) ? 2'b10 : 2'b01);
      check("rr_rsp", rsp, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) check("rr_spacing", nw, 1);
    end
    req_valid_i = 2'b00;

    // NACKed write, then the other requester is still served
    set_req(0, 1'b0, 8'hD0, 8'h6B, 8'h00, 8'd2);
    req_valid_i = 2'b01;
    serve(1'b1, 1'b0, 32'hD06B0002, 8'h00, 1'b1, 1'b0, rdy, nw, rsp, dat, err);
    check("nack_rsp", rsp, 2'b01);
    check("nack_err", err, 1'b1);
    check("nack_no_timeout", timeout_o, 1'b0);
    set_req(1, 1'b0, 8'hD0, 8'h1C, 8'h55, 8'd2);
    req_valid_i = 2'b10;
    serve(1'b1, 1'b0, 32'hD01C5502, 8'h00, 1'b0, 1'b0, rdy, nw, rsp, dat, err);
    check("after_nack_rsp", rsp, 2'b10);
    check("after_nack_err", err, 1'b0);

    // Core never goes busy: watchdog fires 16 cycles after WAIT_BUSY entry
    req_valid_i = 2'b01;
    wait_ready(rdy, nw);
    check("wd_ready", rdy, 2'b01);
    req_valid_i = 2'b00;
    repeat (3) tick();
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      nw++;
      if (rsp_valid_o != 2'b00) break;
    end
    check("wd_latency", nw, 16);
    check("wd_rsp", rsp_valid_o, 2'b01);
    check("wd_err", rsp_error_o, 1'b1);
    check("wd_timeout_flag", timeout_o, 1'b1);
    repeat (2) tick();

    // Reset during WAIT_DONE after granting requester 0
    set_req(0, 1'b0, 8'hD0, 8'h6B, 8'h00, 8'd2);
    req_valid_i = 2'b01;
    wait_ready(rdy, nw);
    check("rst_pre_ready", rdy, 2'b01);
    req_valid_i = 2'b00;
    repeat (3) tick();
    i2c_busy_i = 1'b1;
    tick();
    check("timeout_sticky", timeout_o, 1'b1);
    reset_n_i = 1'b0;
    tick();
    check("midreset_outputs", {req_ready_o, rsp_valid_o, rsp_data_o, rsp_error_o, i2c_write_o,
          i2c_read_o, i2c_slave_addr_o, i2c_din_o, i2c_command_byte_o, i2c_num_bytes_o, timeout_o}, 64'd0);
    reset_n_i  = 1'b1;
    i2c_busy_i = 1'b0;
    seen = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen = seen | rsp_valid_o;
    end
    check("no_rsp_after_reset", seen, 2'b00);
    set_req(1, 1'b0, 8'hD0, 8'h6B, 8'h01, 8'd2);
    req_valid_i = 2'b11;
    serve(1'b1, 1'b0, 32'hD06B0002, 8'h00, 1'b0, 1'b0, rdy, nw, rsp, dat, err);
    check("post_reset_ready", rdy, 2'b01);
    check("post_reset_rsp", rsp, 2'b01);
    req_valid_i = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_arbiter.md
# i2c_arbiter

Shares the single Efinix I2C Core between NUM_REQ independent transaction masters (the level FSM plus future sensor/config clients). Each requester posts one write or read transaction. The block grants requesters round-robin and drives the core's command fields and strobes. It then waits for completion, checks ACK/arbitration status, and returns one response pulse with data and an error flag. A watchdog prevents a stuck core from hanging the system.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- TIMEOUT_CYCLES, 100000: max cycles in any wait state before the transaction is aborted with error.
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, synchronous, active-low.
- req_valid_i  in  NUM_REQ  requester k has a pending transaction; held until req_ready_o[k].
- req_rnw_i  in  NUM_REQ  1 = read, 0 = write.
- req_slave_addr_i  in  8*NUM_REQ  8-bit slave address per requester (7-bit address, LSB 0).
- req_command_byte_i  in  8*NUM_REQ  register/command byte.
- req_din_i  in  8*NUM_REQ  write data (ignored for reads).
- req_num_bytes_i  in  8*NUM_REQ  byte count including command byte.
- req_ready_o  out  NUM_REQ  one-cycle accept pulse; fields captured this cycle.
- rsp_valid_o  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_data_o  out  8  read data, valid with rsp_valid_o; 0 for writes.
- rsp_error_o  out  1  NACK, arbitration lost or timeout; valid with rsp_valid_o.
- i2c_busy_i, i2c_rxak_i, i2c_arb_lost_i, i2c_write_done_i, i2c_data_out_valid_i  in  1 each  core status.
- i2c_data_out_i  in  8  core read data.
- i2c_write_o, i2c_read_o  out  1 each  core strobes.
- i2c_slave_addr_o, i2c_din_o, i2c_command_byte_o, i2c_num_bytes_o  out  8 each  core command fields.
- timeout_o  out  1  sticky; set on any watchdog expiry, cleared only by reset.

## Operation
- States: IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_DONE, VERIFY, RESPOND, DRAIN.
- IDLE
  - When any req_valid_i is set and i2c_busy_i = 0, pick the winner round-robin, starting at last_grant+1 and wrapping.
  - Pulse req_ready_o[winner], capture its fields and rnw, update last_grant, then go to LOAD.
  - No grant while i2c_busy_i = 1.
- LOAD: i2c_* command fields are already driven from the captured registers; wait one settle cycle, then go to STROBE.
- STROBE: i2c_write_o (rnw = 0) or i2c_read_o (rnw = 1) is high for exactly this one cycle; then go to WAIT_BUSY.
- WAIT_BUSY: go to WAIT_DONE on i2c_busy_i = 1.
- WAIT_DONE
  - Write: go to VERIFY on i2c_write_done_i.
  - Read: go to VERIFY on i2c_data_out_valid_i, latching i2c_data_out_i.
- VERIFY: set error as follows, then go to RESPOND.
  - Write passes when arb_lost = 0 and rxak = 0.
  - Read passes when arb_lost = 0 and rxak = 1 (master NACKs the final byte).
- RESPOND: pulse rsp_valid_o[owner] with rsp_data_o and rsp_error_o; go to DRAIN.
- DRAIN: wait for i2c_busy_i = 0, then go to IDLE.
- Watchdog
  - The counter clears on every state change. It counts in WAIT_BUSY, WAIT_DONE and DRAIN.
  - Reaching TIMEOUT_CYCLES-1 in WAIT_BUSY or WAIT_DONE: go to RESPOND with error = 1, set timeout_o.
  - Reaching TIMEOUT_CYCLES-1 in DRAIN: go to IDLE, set timeout_o.
- Unknown state encoding: go to IDLE.
- Only one transaction is in flight at a time. A requester re-asserting valid after its response competes normally; round-robin guarantees the others are not starved.
- Reset mid-transaction: immediately return to IDLE with all outputs at reset values. No response is issued for the aborted transaction.

## Timing
- Reset values: every output 0 (strobes, command fields, req_ready_o, rsp_*, timeout_o). Internal state: last_grant = NUM_REQ-1, so requester 0 wins first; state = IDLE.
- All outputs are registered; strobes are decoded from registered state bits so they are glitch-free.
- Accept cycle T: req_ready_o high.
- T+1: LOAD, fields stable on i2c_*.
- T+2: strobe high.
- The strobe is never asserted before the command fields have been stable for at least 1 cycle.
- rsp_valid_o rises 2 cycles after the write_done/data_out_valid edge: VERIFY, then RESPOND.
- Minimum accept-to-accept spacing with an instant core: 8 cycles.
- Command fields hold their last values after a transaction; they are not cleared.

## Structure
- Package i2c_arb_pkg holds:
  - the state_e typedef;
  - the TIMEOUT default;
  - MPU-6050 constants: slave address 8'hD0, wake register 8'h6B, accel register 8'h3D.
- Sub-module i2c_rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant and binary index.
  - Instantiated once.

## Test plan
- Single write, req0 (addr D0, cmd 6B, din 00, nb 2), core ACKs:
  - req_ready_o = 01 at T; i2c_write_o high at T+2 only;
  - rsp_valid_o = 01 with rsp_error_o = 0.
- Single read, req1 (addr D0, cmd 3D), core returns 8'hFC with rxak = 1:
  - rsp_valid_o = 10, rsp_data_o = FC, rsp_error_o = 0.
- Both requests held continuously, NUM_REQ = 2: grants alternate 0,1,0,1 over 4 transactions; no two rsp pulses in one cycle.
- Write with rxak = 1 (NACK): rsp_error_o = 1, timeout_o stays 0, and the next request is still served.
- Busy never asserted after strobe, TIMEOUT_CYCLES = 16:
  - rsp_error_o = 1 exactly 16 cycles after WAIT_BUSY entry;
  - timeout_o = 1, then return to IDLE.
- reset_n_i low during WAIT_DONE: next cycle all outputs 0, no rsp pulse; after release, requester 0 is granted first.
